// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one byte-addressed data memory between the pipeline MEM stage
//   (cpu_*) and the loader/debug port (ext_*). Each access runs
//   IDLE -> ACCESS -> RESP: arbitration and request latching in IDLE, one memory
//   cycle in ACCESS, and a one-cycle ack (with err and extended load data) in RESP.
//
//   Configuration macro: DMEM_ARB_RR_EN
//     defined   -> round-robin arbitration using a 1-bit last-grant flag.
//     undefined -> fixed cpu priority, plus a starvation counter that forces an
//                  ext grant after STARVE_LIMIT cpu grants made while ext_req is high.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cpu_req/we/size/signed/addr/wdata   cpu request, held until cpu_ack
//   cpu_ack/err/rdata   completion pulse, error flag, load result (held)
//   ext_*               same set as cpu_*, for the loader/debug port
//   dm_ena/w/r          memory enable / write strobe / read strobe (ACCESS only)
//   dm_byteena          byte enables relative to dm_addr
//   dm_addr/dm_wdata    memory address / write data (hold outside ACCESS)
//   dm_rdata            combinational read data from memory
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [1:0]        ext_size,
  input  logic              ext_signed,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic              ext_err,
  output logic [31:0]       ext_rdata,
  output logic              dm_ena,
  output logic              dm_w,
  output logic              dm_r,
  output logic [3:0]        dm_byteena,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t r_state;
  state_t w_state_next;

  // Request latch
  logic              r_owner_ext;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_ext_rdata;

  logic              w_any_req;
  logic              w_pick_ext;
  logic [1:0]        w_sel_size;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_grant;
  logic              w_dm_ena, w_dm_w, w_dm_r;
  logic [3:0]        w_dm_be;
  logic              w_cpu_ack, w_ext_ack;
  logic [31:0]       w_load_data;

  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    case (size)
      2'b00:   size_to_be = 4'b0001;
      2'b01:   size_to_be = 4'b0011;
      2'b10:   size_to_be = 4'b1111;
      default: size_to_be = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a_lo[0];
      2'b10:   misaligned = |a_lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] d);
    case (size)
      2'b00:   extend = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{sgn & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign w_any_req  = cpu_req | ext_req;
  assign w_grant    = (r_state == S_IDLE) && w_any_req;
  assign w_sel_size = w_pick_ext ? ext_size : cpu_size;
  assign w_sel_addr = w_pick_ext ? ext_addr : cpu_addr;

`ifdef DMEM_ARB_RR_EN
  // Favour whichever port was not served last; resets to "ext last".
  logic r_last_ext;

  assign w_pick_ext = ext_req && (!cpu_req || !r_last_ext);

  always_ff @(posedge clk) begin
    if (rst)
      r_last_ext <= 1'b1;
    else if (w_grant)
      r_last_ext <= w_pick_ext;
  end
`else
  // Counts cpu grants made while ext is waiting; saturates at the limit,
  // at which point ext wins the next arbitration.
  localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  assign w_pick_ext = ext_req && (!cpu_req || (r_starve_cnt >= STARVE_C));

  always_ff @(posedge clk) begin
    if (rst || !ext_req)
      r_starve_cnt <= 4'd0;
    else if (w_grant) begin
      if (w_pick_ext)
        r_starve_cnt <= 4'd0;
      else if (r_starve_cnt < STARVE_C)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // rst gates the strobes combinationally so a reset landing in ACCESS
  // never lets the falling-edge write happen.
  always_comb begin
    w_state_next = r_state;
    w_dm_ena     = 1'b0;
    w_dm_w       = 1'b0;
    w_dm_r       = 1'b0;
    w_dm_be      = 4'b0000;
    w_cpu_ack    = 1'b0;
    w_ext_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req)
          w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_state_next = S_RESP;
        if (!r_err && !rst) begin
          w_dm_ena = 1'b1;
          w_dm_w   = r_we;
          w_dm_r   = !r_we;
          w_dm_be  = size_to_be(r_size);
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
        if (!rst) begin
          w_cpu_ack = !r_owner_ext;
          w_ext_ack = r_owner_ext;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_ext <= 1'b0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_err       <= 1'b0;
    end else if (w_grant) begin
      r_owner_ext <= w_pick_ext;
      r_we        <= w_pick_ext ? ext_we     : cpu_we;
      r_size      <= w_sel_size;
      r_signed    <= w_pick_ext ? ext_signed : cpu_signed;
      r_addr      <= w_sel_addr;
      r_wdata     <= w_pick_ext ? ext_wdata  : cpu_wdata;
      r_err       <= misaligned(w_sel_size, w_sel_addr[1:0]);
    end
  end

  assign w_load_data = extend(r_size, r_signed, dm_rdata);

  // Load data is captured at the end of ACCESS so it is valid alongside the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rdata <= 32'h0;
      r_ext_rdata <= 32'h0;
    end else if (r_state == S_ACCESS && !r_we && !r_err) begin
      if (r_owner_ext)
        r_ext_rdata <= w_load_data;
      else
        r_cpu_rdata <= w_load_data;
    end
  end

  assign cpu_ack    = w_cpu_ack;
  assign ext_ack    = w_ext_ack;
  assign cpu_err    = w_cpu_ack && r_err;
  assign ext_err    = w_ext_ack && r_err;
  assign cpu_rdata  = r_cpu_rdata;
  assign ext_rdata  = r_ext_rdata;
  assign dm_ena     = w_dm_ena;
  assign dm_w       = w_dm_w;
  assign dm_r       = w_dm_r;
  assign dm_byteena = w_dm_be;
  assign dm_addr    = r_addr;
  assign dm_wdata   = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_signed;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we, ext_signed;
  logic [1:0]  ext_size;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_ack, ext_err;
  logic [31:0] ext_rdata;
  logic        dm_ena, dm_w, dm_r;
  logic [3:0]  dm_byteena;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_size(ext_size), .ext_signed(ext_signed),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_err(ext_err),
    .ext_rdata(ext_rdata),
    .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r), .dm_byteena(dm_byteena),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Byte-addressed memory model: write on falling edge, combinational read.
  logic [7:0] mem [0:255];
  logic       mem_clr;
  logic [7:0] ra;
  assign ra = dm_addr[7:0];
  assign dm_rdata = (dm_ena && dm_r) ?
                    {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]} : 32'h0;

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (dm_ena && dm_w) begin
      for (int i = 0; i < 4; i++)
        if (dm_byteena[i]) mem[8'(dm_addr[7:0] + i)] <= dm_wdata[8*i +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic        port;     // 0 cpu, 1 ext
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  // Issues one request on a port, waits (bounded) for its ack and reports
  // latency in cycles, err, byte enables seen while dm_ena, and rdata.
  task automatic access(input logic port, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [3:0] be,
                        output logic ena_seen, output logic wrong_ack,
                        output logic [31:0] rd);
    lat = -1; err = 1'b0; be = 4'h0; ena_seen = 1'b0; wrong_ack = 1'b0; rd = 32'h0;
    if (port) begin
      ext_we = we; ext_size = size; ext_signed = sgn; ext_addr = addr; ext_wdata = wdata;
      ext_req = 1'b1;
    end else begin
      cpu_we = we; cpu_size = size; cpu_signed = sgn; cpu_addr = addr; cpu_wdata = wdata;
      cpu_req = 1'b1;
    end
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (dm_ena) begin ena_seen = 1'b1; be = dm_byteena; end
      if (port ? cpu_ack : ext_ack) wrong_ack = 1'b1;
      if (port ? ext_ack : cpu_ack) begin
        lat = n;
        err = port ? ext_err : cpu_err;
        rd  = port ? ext_rdata : cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    ext_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic        err, ena_seen, wrong_ack;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        grants [$];
    logic [9:0]  exp_order;

    rst = 1'b1; mem_clr = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_signed = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_size = 0; ext_signed = 0; ext_addr = 0; ext_wdata = 0;

    //            port we  size  sgn addr   wdata          err be    chk rd
    vecs[0]  = '{1'b0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 4'hF, 0, 32'h0};
    vecs[1]  = '{1'b0, 0, 2'b10, 0, 32'h10, 32'h0,        0, 4'hF, 1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1, 2'b00, 0, 32'h21, 32'hAAAAAA80, 0, 4'h1, 0, 32'h0};
    vecs[3]  = '{1'b0, 0, 2'b00, 1, 32'h21, 32'h0,        0, 4'h1, 1, 32'hFFFFFF80};
    vecs[4]  = '{1'b0, 0, 2'b00, 0, 32'h21, 32'h0,        0, 4'h1, 1, 32'h00000080};
    vecs[5]  = '{1'b0, 0, 2'b10, 0, 32'h20, 32'h0,        0, 4'hF, 1, 32'h00008000};
    vecs[6]  = '{1'b0, 0, 2'b10, 0, 32'h12, 32'h0,        1, 4'h0, 0, 32'h0};
    vecs[7]  = '{1'b0, 1, 2'b10, 0, 32'h12, 32'h55555555, 1, 4'h0, 0, 32'h0};
    vecs[8]  = '{1'b0, 0, 2'b10, 0, 32'h10, 32'h0,        0, 4'hF, 1, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1, 2'b01, 0, 32'h30, 32'hFFFF1234, 0, 4'h3, 0, 32'h0};
    vecs[10] = '{1'b1, 0, 2'b01, 1, 32'h30, 32'h0,        0, 4'h3, 1, 32'h00001234};
    vecs[11] = '{1'b1, 1, 2'b01, 0, 32'h32, 32'h00008001, 0, 4'h3, 0, 32'h0};
    vecs[12] = '{1'b1, 0, 2'b01, 1, 32'h32, 32'h0,        0, 4'h3, 1, 32'hFFFF8001};
    vecs[13] = '{1'b1, 0, 2'b01, 0, 32'h32, 32'h0,        0, 4'h3, 1, 32'h00008001};
    vecs[14] = '{1'b1, 0, 2'b10, 0, 32'h30, 32'h0,        0, 4'hF, 1, 32'h80011234};
    vecs[15] = '{1'b1, 0, 2'b01, 0, 32'h31, 32'h0,        1, 4'h0, 0, 32'h0};
    vecs[16] = '{1'b1, 0, 2'b11, 0, 32'h40, 32'h0,        1, 4'h0, 0, 32'h0};
    vecs[17] = '{1'b1, 0, 2'b00, 1, 32'h33, 32'h0,        0, 4'h1, 1, 32'hFFFFFF80};
    vecs[18] = '{1'b0, 0, 2'b01, 1, 32'h20, 32'h0,        0, 4'h3, 1, 32'hFFFF8000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_acks",  {30'h0, cpu_ack, ext_ack}, 32'h0);
    chk("rst_errs",  {30'h0, cpu_err, ext_err}, 32'h0);
    chk("rst_strb",  {29'h0, dm_ena, dm_w, dm_r}, 32'h0);
    chk("rst_be",    {28'h0, dm_byteena}, 32'h0);
    chk("rst_cpu_rd", cpu_rdata, 32'h0);
    chk("rst_ext_rd", ext_rdata, 32'h0);
    $display("reset: checked idle outputs");

    for (int v = 0; v < NV; v++) begin
      access(vecs[v].port, vecs[v].we, vecs[v].size, vecs[v].sgn, vecs[v].addr,
             vecs[v].wdata, lat, err, be, ena_seen, wrong_ack, rd);
      $display("vec %0d: port=%0d we=%0d size=%0d addr=%h lat=%0d err=%0d be=%h rdata=%h",
               v, vecs[v].port, vecs[v].we, vecs[v].size, vecs[v].addr, lat, err, be, rd);
      chk($sformatf("v%0d_latency", v), lat, 2);
      chk($sformatf("v%0d_err", v), {31'h0, err}, {31'h0, vecs[v].exp_err});
      chk($sformatf("v%0d_dm_ena", v), {31'h0, ena_seen}, {31'h0, !vecs[v].exp_err});
      chk($sformatf("v%0d_byteena", v), {28'h0, be}, {28'h0, vecs[v].exp_be});
      chk($sformatf("v%0d_other_ack", v), {31'h0, wrong_ack}, 32'h0);
      if (vecs[v].chk_rd)
        chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
    end

    // Starvation: both ports held continuously.
    cpu_we = 0; cpu_size = 2'b10; cpu_signed = 0; cpu_addr = 32'h10;
    ext_we = 0; ext_size = 2'b10; ext_signed = 0; ext_addr = 32'h30;
    cpu_req = 1'b1; ext_req = 1'b1;
    for (int n = 0; n < 60 && grants.size() < 10; n++) begin
      @(posedge clk); #1;
      if (cpu_ack && ext_ack) chk("starve_double_ack", 32'h1, 32'h0);
      else if (cpu_ack) grants.push_back(1'b0);
      else if (ext_ack) grants.push_back(1'b1);
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("starve_count", grants.size(), 10);
    exp_order = 10'b1000010000;  // bit k = grant k, 1 = ext
    for (int k = 0; k < grants.size(); k++) begin
      $display("starve grant %0d: %s", k, grants[k] ? "ext" : "cpu");
      chk($sformatf("starve_grant%0d", k), {31'h0, grants[k]}, {31'h0, exp_order[k]});
    end

    // Reset in the ACCESS cycle of a store.
    cpu_we = 1; cpu_size = 2'b10; cpu_signed = 0; cpu_addr = 32'h50; cpu_wdata = 32'h11223344;
    cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("midrst_access_ena", {31'h0, dm_ena}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_strobe_gated", {30'h0, dm_ena, dm_w}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    chk("midrst_acks", {30'h0, cpu_ack, ext_ack}, 32'h0);
    chk("midrst_strb", {28'h0, dm_ena, dm_w, dm_r, |dm_byteena}, 32'h0);
    chk("midrst_cpu_rd", cpu_rdata, 32'h0);
    chk("midrst_ext_rd", ext_rdata, 32'h0);
    wrong_ack = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (cpu_ack || ext_ack || dm_ena) wrong_ack = 1'b1;
    end
    chk("midrst_quiet", {31'h0, wrong_ack}, 32'h0);
    chk("midrst_mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h0);
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, lat, err, be, ena_seen, wrong_ack, rd);
    $display("midrst reload: lat=%0d rdata=%h", lat, rd);
    chk("midrst_reload_lat", lat, 2);
    chk("midrst_reload_rd", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
